// File: rtl/da2_pkg.sv
// Shared types and constants for the Pmod DA2 dual-DAC transmitter.
package da2_pkg;

  localparam int unsigned DA2_FRAME_W = 16;
  localparam int unsigned DA2_DATA_W  = 12;
  localparam int unsigned DA2_PD_W    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } da2_state_e;

  typedef enum logic [DA2_PD_W-1:0] {
    PD_NORMAL = 2'b00,
    PD_1K     = 2'b01,
    PD_100K   = 2'b10,
    PD_HIZ    = 2'b11
  } da2_pd_e;

  // On-wire DAC121S101 frame, MSB first.
  typedef struct packed {
    logic [1:0]            rsvd;
    da2_pd_e               pd;
    logic [DA2_DATA_W-1:0] code;
  } da2_frame_t;

  // Assemble one channel's frame from a power-down mode and a code.
  function automatic da2_frame_t da2_frame(input da2_pd_e pd, input logic [DA2_DATA_W-1:0] code);
    da2_frame_t f;
    f.rsvd = 2'b00;
    f.pd   = pd;
    f.code = code;
    return f;
  endfunction

endpackage

// File: rtl/da2_sclk_gen.sv
// SCLK generator: half-period counter, SCLK register, edge strobes and
// terminal flag on the 16th rising transition of a frame.
module da2_sclk_gen
  import da2_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_c,
  output logic fall_c,
  output logic term_c
);

  localparam int unsigned CNT_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int unsigned BIT_W = $clog2(DA2_FRAME_W);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sclk_q, sclk_d;
  logic             half_end;

  assign half_end = en_i && (cnt_q == CNT_W'(SCLK_HALF - 1));
  assign rise_c   = half_end && !sclk_q;
  assign fall_c   = half_end && sclk_q;
  assign term_c   = rise_c && (bit_q == BIT_W'(DA2_FRAME_W - 1));
  assign sclk_o   = sclk_q;

  // Next-state: idle holds SCLK high, enabled toggles every SCLK_HALF cycles.
  always_comb begin
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      bit_d  = '0;
      sclk_d = 1'b1;
    end else if (half_end) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
      if (!sclk_q) begin
        bit_d = bit_q + BIT_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/da2_dual_tx.sv
// Pmod DA2 transmitter: two DAC121S101 frames shifted out in lockstep on
// shared SCLK/SYNC with separate DINA/DINB.
// Build option: define DA2_PD_EN to add the pdMode port (frame bits 13:12);
// otherwise the power-down bits are fixed at normal operation.
module da2_dual_tx
  import da2_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 2,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  update,
  input  logic [DA2_DATA_W-1:0] data0,
  input  logic [DA2_DATA_W-1:0] data1,
`ifdef DA2_PD_EN
  input  logic [DA2_PD_W-1:0]   pdMode,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  SCLK,
  output logic                  SYNC,
  output logic                  DINA,
  output logic                  DINB
);

  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned SH_W  = DA2_FRAME_W - 1;

  da2_state_e             state_q, state_d;
  logic [SH_W-1:0]        sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic                   din_a_q, din_a_d, din_b_q, din_b_d;
  logic                   sync_q, sync_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [GAP_W-1:0]       gap_q, gap_d;

  da2_pd_e                pd_c;
  logic [DA2_FRAME_W-1:0] frame_a_c, frame_b_c;
  logic                   sclk_en_c, sclk_rise, sclk_fall, sclk_term;

`ifdef DA2_PD_EN
  assign pd_c = da2_pd_e'(pdMode);
`else
  assign pd_c = PD_NORMAL;
`endif

  assign frame_a_c = da2_frame(pd_c, data0);
  assign frame_b_c = da2_frame(pd_c, data1);
  assign sclk_en_c = (state_q == SHIFT);

  da2_sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk (
    .clk    (clk),
    .rst    (rst),
    .en_i   (sclk_en_c),
    .sclk_o (SCLK),
    .rise_c (sclk_rise),
    .fall_c (sclk_fall),
    .term_c (sclk_term)
  );

  // Sanity: a single cycle can never carry both SCLK transitions.
  always_comb begin
    if (sclk_rise) begin
      assert (!sclk_fall);
    end
  end

  // Next-state and output decode for IDLE -> SHIFT -> GAP.
  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    din_a_d = din_a_q;
    din_b_d = din_b_q;
    sync_d  = sync_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (update) begin
          sh_a_d  = frame_a_c[SH_W-1:0];
          sh_b_d  = frame_b_c[SH_W-1:0];
          din_a_d = frame_a_c[DA2_FRAME_W-1];
          din_b_d = frame_b_c[DA2_FRAME_W-1];
          sync_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_term) begin
          sync_d  = 1'b1;
          din_a_d = 1'b0;
          din_b_d = 1'b0;
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = GAP;
        end else if (sclk_rise) begin
          din_a_d = sh_a_q[SH_W-1];
          din_b_d = sh_b_q[SH_W-1];
          sh_a_d  = {sh_a_q[SH_W-2:0], 1'b0};
          sh_b_d  = {sh_b_q[SH_W-2:0], 1'b0};
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      din_a_q <= 1'b0;
      din_b_q <= 1'b0;
      sync_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      din_a_q <= din_a_d;
      din_b_q <= din_b_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gap_q   <= gap_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign SYNC = sync_q;
  assign DINA = din_a_q;
  assign DINB = din_b_q;

endmodule

// File: tb/tb_da2_dual_tx.sv
// Scoreboard bench for da2_dual_tx: a frame-level model pushes expected
// frames on acceptance; a pin monitor rebuilds frames from SCLK falls.
module tb_da2_dual_tx;

  localparam int unsigned SH = 2;
  localparam int unsigned GC = 4;
  localparam int          FL = 32 * SH;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        update = 1'b0;
  logic [11:0] data0 = '0;
  logic [11:0] data1 = '0;
`ifdef DA2_PD_EN
  logic [1:0]  pd_mode = 2'b00;
`endif
  logic        busy, done, SCLK, SYNC, DINA, DINB;

  int   passes = 0;
  int   checks = 0;
  exp_t exp_q[$];
  bit   mon_en = 1'b0;

  // Reference model state (written only by the model process).
  int   cyc = 0;
  int   idle_at = 0;
  int   fe = -1;
  int   abort_cnt = 0;
  logic busy_e = 1'b0;
  logic sync_e = 1'b1;
  logic done_e = 1'b0;

  always #5 clk = ~clk;

  da2_dual_tx #(.SCLK_HALF(SH), .GAP_CYC(GC)) dut (
    .clk    (clk),
    .rst    (rst),
    .update (update),
    .data0  (data0),
    .data1  (data1),
`ifdef DA2_PD_EN
    .pdMode (pd_mode),
`endif
    .busy   (busy),
    .done   (done),
    .SCLK   (SCLK),
    .SYNC   (SYNC),
    .DINA   (DINA),
    .DINB   (DINB)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
  endtask

  function automatic logic [15:0] mk(input logic [11:0] d);
`ifdef DA2_PD_EN
    return {2'b00, pd_mode, d};
`else
    return {4'b0000, d};
`endif
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic rand_inputs();
    data0 = 12'($urandom);
    data1 = 12'($urandom);
`ifdef DA2_PD_EN
    pd_mode = 2'($urandom);
`endif
  endtask

  // Model: a frame accepted at edge N drives SYNC low until edge N+32*SH,
  // pulses done there, keeps busy until N+32*SH+GC, re-accepts from N+32*SH+GC+1.
  initial begin
    int k;
    forever begin
      @(posedge clk);
      k = cyc;
      cyc++;
      if (rst) begin
        if (k < fe) begin
          exp_q.delete(exp_q.size() - 1);
          abort_cnt++;
        end
        idle_at = k + 1;
        fe      = -1;
        busy_e  = 1'b0;
        sync_e  = 1'b1;
        done_e  = 1'b0;
      end else if (update && k >= idle_at) begin
        exp_t e;
        e.a = mk(data0);
        e.b = mk(data1);
        exp_q.push_back(e);
        idle_at = k + FL + GC + 1;
        fe      = k + FL;
        busy_e  = 1'b1;
        sync_e  = 1'b0;
        done_e  = 1'b0;
      end else begin
        busy_e = (k + 1 < idle_at);
        sync_e = !(k < fe);
        done_e = (k == fe);
      end
    end
  end

  // Monitor: per-cycle handshake checks plus frame reconstruction.
  int abort_seen = 0;
  initial begin
    logic psync, psclk, pdina, pdinb;
    int falls, lowc, stab_bad;
    logic [15:0] ca, cb;
    exp_t e;
    psync = 1'b1; psclk = 1'b1; pdina = 1'b0; pdinb = 1'b0;
    falls = 0; lowc = 0; stab_bad = 0; ca = '0; cb = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("busy", 32'(busy), 32'(busy_e));
        chk("sync", 32'(SYNC), 32'(sync_e));
        chk("done", 32'(done), 32'(done_e));
        if (SYNC) chk("sclk_high_when_sync_high", 32'(SCLK), 32'd1);
        if (psync && !SYNC) begin
          falls = 0; lowc = 0; stab_bad = 0; ca = '0; cb = '0;
        end
        if (!SYNC) begin
          lowc++;
          if (psclk && !SCLK) begin
            if (DINA !== pdina || DINB !== pdinb) stab_bad++;
            ca = {ca[14:0], DINA};
            cb = {cb[14:0], DINB};
            falls++;
          end
        end
        if (!psync && SYNC) begin
          if (falls != 16) begin
            chk("abort_expected", 32'(abort_seen < abort_cnt), 32'd1);
            abort_seen++;
            chk("abort_dina_low", 32'(DINA), 32'd0);
            chk("abort_dinb_low", 32'(DINB), 32'd0);
          end else if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL frame_unexpected: got frame %h/%h want none at %0t", ca, cb, $time);
          end else begin
            e = exp_q.pop_front();
            chk("frame_dina", 32'(ca), 32'(e.a));
            chk("frame_dinb", 32'(cb), 32'(e.b));
            chk("sync_low_cycles", 32'(lowc), 32'(FL));
            chk("din_stable_at_fall", 32'(stab_bad), 32'd0);
            chk("dina_low_after", 32'(DINA), 32'd0);
            chk("dinb_low_after", 32'(DINB), 32'd0);
          end
        end
      end
      psync = SYNC; psclk = SCLK; pdina = DINA; pdinb = DINB;
    end
  end

  // Stimulus.
  initial begin
    cycles(3);
    chk("rst_sync", 32'(SYNC), 32'd1);
    chk("rst_sclk", 32'(SCLK), 32'd1);
    chk("rst_dina", 32'(DINA), 32'd0);
    chk("rst_dinb", 32'(DINB), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    cycles(2);

    // Single frame with the reference codes.
    data0 = 12'hA5C; data1 = 12'h3F1;
    pulse();
    cycles(FL + GC + 10);

    // update held high: 0x000 frame then 0xFFF frame back-to-back.
    data0 = 12'h000;
    update = 1'b1;
    cycles(10);
    data0 = 12'hFFF;
    cycles(FL + GC + 10);
    rand_inputs();
    cycles(FL + GC);
    update = 1'b0;
    cycles(FL + GC + 10);

    // Mid-frame update and data change are ignored; later frame uses 0x123.
    rand_inputs();
    pulse();
    cycles(9 * 2 * SH);
    data0 = 12'h123;
    pulse();
    cycles(FL + GC + 10);
    pulse();
    cycles(FL + GC + 10);

    // Reset during bit 7, then a clean frame.
    rand_inputs();
    pulse();
    cycles(7 * 2 * SH + 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_sync", 32'(SYNC), 32'd1);
    chk("midrst_sclk", 32'(SCLK), 32'd1);
    chk("midrst_dina", 32'(DINA), 32'd0);
    chk("midrst_dinb", 32'(DINB), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    rand_inputs();
    pulse();
    cycles(FL + GC + 10);

    // Randomised traffic with occasional holds and resets.
    for (int i = 0; i < 30; i++) begin
      rand_inputs();
      if ($urandom_range(3) == 0) begin
        update = 1'b1;
        cycles($urandom_range(FL * 2, FL * 3));
        update = 1'b0;
      end else begin
        pulse();
      end
      cycles($urandom_range(0, FL + GC + 20));
      if ($urandom_range(9) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    update = 1'b0;
    cycles(FL + GC + 20);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("aborts_matched", 32'(abort_seen), 32'(abort_cnt));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
